// File: rtl/ws2812_rx.sv
// ws2812_rx
// Receives a WS2812 single-wire NRZ stream and decodes it into 24-bit pixel
// words. Each word is tagged with its index in the frame. A long low period
// (the latch) closes the frame. Typical uses are checking a ws2812 driver
// through a loopback pin, or acting as the input stage of a sniffed or
// cascaded LED chain.
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   ws_in       in   1   serial data pin, asynchronous to clk
//   rgb_data    out  24  decoded word 24'hRR_GG_BB (the wire carries G,R,B)
//   led_num     out  8   0-based index of the word in the current frame
//   valid       out  1   1-cycle strobe: rgb_data/led_num updated
//   frame_done  out  1   1-cycle strobe: latch seen after >=1 received bit
//   led_count   out  8   words in the last completed frame
//   bit_error   out  1   1-cycle strobe: over-long high or partial word at latch
module ws2812_rx #(
    parameter int BIT_THRESH   = 7,
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = 600,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_in,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic [7:0]  led_count,
    output logic        bit_error
);

    localparam logic [CNT_W-1:0] LATCH_CNT    = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_CNT_M1 = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LIMIT   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] ONE_LIMIT    = CNT_W'(BIT_THRESH);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t           state;
    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] lcnt;
    logic [CNT_W-1:0] lcnt_next;
    logic [CNT_W-1:0] hcnt;
    logic [22:0]      shreg;
    logic [4:0]       bitcnt;
    logic [7:0]       index;
    logic             latch_hit;
    logic             bit_val;
    logic [23:0]      word_next;

    // Two-flop synchroniser followed by a registered edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_1    <= ws_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            rise      <= sync_2 & ~sync_prev;
            fall      <= ~sync_2 & sync_prev;
        end
    end

    // The low counter follows the synced level directly, so it measures
    // the true low time regardless of the edge detector delay. latch_hit
    // fires only on the cycle the count first reaches RESET_CYCLES.
    always_comb begin
        lcnt_next = lcnt;
        if (sync_2) begin
            lcnt_next = '0;
        end else if (lcnt != LATCH_CNT) begin
            lcnt_next = lcnt + 1'b1;
        end
        latch_hit = ~sync_2 && (lcnt == LATCH_CNT_M1);
        bit_val   = (hcnt >= ONE_LIMIT);
        word_next = {shreg, bit_val};
    end

    // Main decoder FSM with registered outputs. hcnt is loaded with 1 on the
    // rise so that on the falling-edge cycle it equals the high-pulse length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            lcnt       <= '0;
            hcnt       <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            index      <= '0;
            rgb_data   <= '0;
            led_num    <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            led_count  <= '0;
            bit_error  <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            bit_error  <= 1'b0;
            lcnt       <= lcnt_next;
            case (state)
                SYNC: begin
                    if (latch_hit) begin
                        bitcnt <= '0;
                        index  <= '0;
                        state  <= IDLE;
                    end
                end
                IDLE, LOW: begin
                    if (rise) begin
                        hcnt  <= CNT_W'(1);
                        state <= HIGH;
                    end else if (latch_hit && (bitcnt != '0 || index != '0)) begin
                        frame_done <= 1'b1;
                        led_count  <= index;
                        bit_error  <= (bitcnt != '0);
                        bitcnt     <= '0;
                        index      <= '0;
                        state      <= IDLE;
                    end
                end
                HIGH: begin
                    if (hcnt > HIGH_LIMIT) begin
                        bit_error <= 1'b1;
                        bitcnt    <= '0;
                        index     <= '0;
                        state     <= SYNC;
                    end else if (fall) begin
                        shreg <= word_next[22:0];
                        state <= LOW;
                        if (bitcnt == 5'd23) begin
                            valid    <= 1'b1;
                            rgb_data <= {word_next[15:8], word_next[23:16], word_next[7:0]};
                            led_num  <= index;
                            bitcnt   <= '0;
                            if (index != 8'hFF) begin
                                index <= index + 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule
